cmp_branch_unit: RTL

CMP_BRANCH_UNIT -- requirements
Module: cmp_branch_unit

---
 rtl/cmp_branch_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/cmp_branch_unit.sv
// Byte-serial compare/branch unit: SLT/SLTU and MIPS-style branch conditions.
// Compares four bytes MSB-first over a fixed five-cycle operation.
module cmp_branch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        lt,
  output logic        eq,
  output logic        taken
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [2:0] OP_SLT  = 3'b000;
  localparam logic [2:0] OP_SLTU = 3'b001;
  localparam logic [2:0] OP_BEQ  = 3'b010;
  localparam logic [2:0] OP_BNE  = 3'b011;
  localparam logic [2:0] OP_BLEZ = 3'b100;
  localparam logic [2:0] OP_BGTZ = 3'b101;
  localparam logic [2:0] OP_BLTZ = 3'b110;
  localparam logic [2:0] OP_BGEZ = 3'b111;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  idx_q, idx_d;
  logic        decided_q, decided_d;
  logic        lt_acc_q, lt_acc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic        lt_q, lt_d;
  logic        eq_q, eq_d;
  logic        taken_q, taken_d;

  logic [7:0]  byte_a;
  logic [7:0]  byte_b;
  logic        step_diff;
  logic        dec_n;
  logic        lt_n;
  logic        eq_n;
  logic [31:0] sign_flip;
  logic [31:0] b_in;

  function automatic logic branch_cond(
    input logic [2:0] f_op,
    input logic       f_lt,
    input logic       f_eq
  );
    logic r;
    r = 1'b0;
    unique case (f_op)
      OP_BEQ:  r = f_eq;
      OP_BNE:  r = ~f_eq;
      OP_BLEZ: r = f_lt | f_eq;
      OP_BGTZ: r = ~f_lt & ~f_eq;
      OP_BLTZ: r = f_lt;
      OP_BGEZ: r = ~f_lt;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Flipping bit 31 maps two's-complement order onto unsigned order.
  assign sign_flip = {(op != OP_SLTU), 31'b0};
  assign b_in      = op[2] ? 32'd0 : b;

  assign byte_a    = a_q[{idx_q, 3'b000} +: 8];
  assign byte_b    = b_q[{idx_q, 3'b000} +: 8];
  assign step_diff = (byte_a != byte_b);
  assign dec_n     = decided_q | step_diff;
  assign lt_n      = decided_q ? lt_acc_q : (byte_a < byte_b);
  assign eq_n      = ~dec_n;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    lt_acc_d  = lt_acc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    lt_d      = lt_q;
    eq_d      = eq_q;
    taken_d   = taken_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start) begin
          state_d   = S_CMP;
          busy_d    = 1'b1;
          op_d      = op;
          a_d       = a ^ sign_flip;
          b_d       = b_in ^ sign_flip;
          idx_d     = 2'd3;
          decided_d = 1'b0;
          lt_acc_d  = 1'b0;
        end
      end
      (state_q == S_CMP): begin
        decided_d = dec_n;
        lt_acc_d  = lt_n;
        idx_d     = idx_q - 2'd1;
        if (idx_q == 2'd0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          eq_d    = eq_n;
          lt_d    = lt_n;
          result_d = op_q[2:1] == 2'b00 ?
                     {31'b0, lt_n} : 32'd0;
          taken_d = branch_cond(op_q, lt_n, eq_n);
        end
      end
      (state_q == S_DONE): begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= 3'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      idx_q     <= 2'd0;
      decided_q <= 1'b0;
      lt_acc_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 32'd0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      taken_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      lt_acc_q  <= lt_acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      lt_q      <= lt_d;
      eq_q      <= eq_d;
      taken_q   <= taken_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign lt     = lt_q;
  assign eq     = eq_q;
  assign taken  = taken_q;

endmodule
